// File: rtl/demux1x2_reg.sv
// -----------------------------------------------------------------------------
// demux1x2_reg
//
// Registered 1-to-2 demultiplexer with valid/ready flow control. A word offered
// on d is steered to channel a (sel=0) or channel b (sel=1). Each channel holds
// one word in a single-entry register and counts the words it has delivered.
//
// Handshake semantics (all interfaces): a transfer happens on a rising edge of
// Clk when valid and ready are both 1 in the cycle before that edge. A valid
// that is raised stays up, with its payload stable, until the transfer happens.
// Ready may be raised or dropped freely and never depends on the same
// interface's valid.
//
// Ports:
//   Clk      in   clock, all state updates on rising edge
//   Rst      in   synchronous reset, active-low
//   d        in   input data word (DATAWIDTH)
//   sel      in   destination select: 0 -> channel a, 1 -> channel b
//   d_valid  in   producer offers d/sel this cycle
//   d_ready  out  block accepts d/sel this cycle (combinational)
//   a        out  channel a data register (DATAWIDTH)
//   a_valid  out  channel a holds an undelivered word (this is the FSM state)
//   a_ready  in   consumer a accepts the word this cycle
//   b        out  channel b data register (DATAWIDTH)
//   b_valid  out  channel b holds an undelivered word (this is the FSM state)
//   b_ready  in   consumer b accepts the word this cycle
//   a_count  out  words delivered on channel a, wraps (CNTWIDTH)
//   b_count  out  words delivered on channel b, wraps (CNTWIDTH)
// -----------------------------------------------------------------------------
module demux1x2_reg #(
  parameter int DATAWIDTH = 8,
  parameter int CNTWIDTH  = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] d,
  input  logic                 sel,
  input  logic                 d_valid,
  output logic                 d_ready,
  output logic [DATAWIDTH-1:0] a,
  output logic                 a_valid,
  input  logic                 a_ready,
  output logic [DATAWIDTH-1:0] b,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [CNTWIDTH-1:0]  a_count,
  output logic [CNTWIDTH-1:0]  b_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

  localparam logic [CNTWIDTH-1:0] CNT_ONE = CNTWIDTH'(1);

  chan_state_t a_state, a_state_nxt;
  chan_state_t b_state, b_state_nxt;

  logic acc;
  logic ld_a, ld_b;
  logic del_a, del_b;

  // The valid outputs are the channel state bits, so the FSM state is
  // directly observable on the ports.
  assign a_valid = (a_state == FULL);
  assign b_valid = (b_state == FULL);

  always_comb begin
    d_ready     = 1'b0;
    acc         = 1'b0;
    ld_a        = 1'b0;
    ld_b        = 1'b0;
    del_a       = 1'b0;
    del_b       = 1'b0;
    a_state_nxt = a_state;
    b_state_nxt = b_state;

    // A full target can still accept when its consumer is draining it in the
    // same cycle; this gives one word per cycle of pass-through throughput.
    if (sel) d_ready = Rst & ((b_state == EMPTY) | b_ready);
    else     d_ready = Rst & ((a_state == EMPTY) | a_ready);

    acc   = d_valid & d_ready;
    ld_a  = acc & ~sel;
    ld_b  = acc & sel;
    del_a = (a_state == FULL) & a_ready;
    del_b = (b_state == FULL) & b_ready;

    case (a_state)
      EMPTY:   if (ld_a) a_state_nxt = FULL;
      FULL:    if (del_a && !ld_a) a_state_nxt = EMPTY;
      default: a_state_nxt = EMPTY;
    endcase

    case (b_state)
      EMPTY:   if (ld_b) b_state_nxt = FULL;
      FULL:    if (del_b && !ld_b) b_state_nxt = EMPTY;
      default: b_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      a_state <= EMPTY;
      b_state <= EMPTY;
      a       <= '0;
      b       <= '0;
      a_count <= '0;
      b_count <= '0;
    end else begin
      a_state <= a_state_nxt;
      b_state <= b_state_nxt;
      // Data registers keep their last value after delivery; only a load
      // overwrites them.
      if (ld_a)  a <= d;
      if (ld_b)  b <= d;
      if (del_a) a_count <= a_count + CNT_ONE;
      if (del_b) b_count <= b_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_demux1x2_reg.sv
// -----------------------------------------------------------------------------
// tb_demux1x2_reg
//
// Directed bench for demux1x2_reg. Inputs change 1 time unit after a rising
// edge; outputs are sampled 1 unit after that (combinational d_ready) or 1 unit
// after the next edge (registered outputs).
// -----------------------------------------------------------------------------
module tb_demux1x2_reg;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          Clk;
  logic          Rst;
  logic [DW-1:0] d;
  logic          sel;
  logic          d_valid;
  logic          d_ready;
  logic [DW-1:0] a;
  logic          a_valid;
  logic          a_ready;
  logic [DW-1:0] b;
  logic          b_valid;
  logic          b_ready;
  logic [CW-1:0] a_count;
  logic [CW-1:0] b_count;

  int passed = 0;
  int total  = 0;

  demux1x2_reg #(.DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .d       (d),
    .sel     (sel),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .a       (a),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b       (b),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .a_count (a_count),
    .b_count (b_count)
  );

  // clock / reset block
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance past one rising edge; registered outputs are settled on return.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; d = 8'h55; sel = 1'b0; d_valid = 1'b1;
    a_ready = 1'b0; b_ready = 1'b0;
    step(); step();
    total++; if (d_ready !== 1'b0) $display("FAIL reset_d_ready: got %0b expected 0", d_ready); else passed++;
    total++; if (a !== 8'h00) $display("FAIL reset_a: got %0h expected 0", a); else passed++;
    total++; if (b !== 8'h00) $display("FAIL reset_b: got %0h expected 0", b); else passed++;
    total++; if (a_valid !== 1'b0 || b_valid !== 1'b0) $display("FAIL reset_valids: got %0b%0b expected 00", a_valid, b_valid); else passed++;
    Rst = 1'b1; d_valid = 1'b0;
    step();
    total++; if (a_count !== 8'd0 || b_count !== 8'd0) $display("FAIL reset_counts: got %0d/%0d expected 0/0", a_count, b_count); else passed++;
    total++; if (a_valid !== 1'b0 || b_valid !== 1'b0) $display("FAIL reset_valids_after: got %0b%0b expected 00", a_valid, b_valid); else passed++;
  endtask

  task automatic test_single_steer();
    d = 8'd20; sel = 1'b0; d_valid = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
    settle();
    total++; if (d_ready !== 1'b1) $display("FAIL steer_d_ready: got %0b expected 1", d_ready); else passed++;
    step();
    d_valid = 1'b0;
    total++; if (a !== 8'd20 || a_valid !== 1'b1) $display("FAIL steer_a_loaded: got a=%0d v=%0b expected a=20 v=1", a, a_valid); else passed++;
    total++; if (a_count !== 8'd0) $display("FAIL steer_count_before: got %0d expected 0", a_count); else passed++;
    step();
    total++; if (a_valid !== 1'b0) $display("FAIL steer_a_drained: got %0b expected 0", a_valid); else passed++;
    total++; if (a_count !== 8'd1) $display("FAIL steer_a_count: got %0d expected 1", a_count); else passed++;
    total++; if (a !== 8'd20) $display("FAIL steer_a_holds: got %0d expected 20", a); else passed++;
    total++; if (b_valid !== 1'b0 || b_count !== 8'd0) $display("FAIL steer_b_idle: got v=%0b c=%0d expected v=0 c=0", b_valid, b_count); else passed++;
  endtask

  task automatic test_backpressure();
    b_ready = 1'b0; d = 8'd10; sel = 1'b1; d_valid = 1'b1;
    settle();
    total++; if (d_ready !== 1'b1) $display("FAIL bp_first_ready: got %0b expected 1", d_ready); else passed++;
    step();
    d = 8'd30;
    settle();
    total++; if (d_ready !== 1'b0) $display("FAIL bp_blocked: got %0b expected 0", d_ready); else passed++;
    step();
    total++; if (b !== 8'd10 || b_valid !== 1'b1) $display("FAIL bp_held: got b=%0d v=%0b expected b=10 v=1", b, b_valid); else passed++;
    total++; if (b_count !== 8'd0) $display("FAIL bp_count_held: got %0d expected 0", b_count); else passed++;
    b_ready = 1'b1;
    settle();
    total++; if (d_ready !== 1'b1) $display("FAIL bp_pass_ready: got %0b expected 1", d_ready); else passed++;
    step();
    d_valid = 1'b0;
    total++; if (b !== 8'd30 || b_valid !== 1'b1) $display("FAIL bp_pass_load: got b=%0d v=%0b expected b=30 v=1", b, b_valid); else passed++;
    total++; if (b_count !== 8'd1) $display("FAIL bp_count1: got %0d expected 1", b_count); else passed++;
    step();
    total++; if (b_valid !== 1'b0 || b_count !== 8'd2) $display("FAIL bp_count2: got v=%0b c=%0d expected v=0 c=2", b_valid, b_count); else passed++;
  endtask

  task automatic test_interleave();
    logic [DW-1:0] words [4];
    words[0] = 8'd15; words[1] = 8'd16; words[2] = 8'd17; words[3] = 8'd18;
    // a_count=1, b_count=2 on entry
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = words[i]; sel = i[0]; d_valid = 1'b1;
      settle();
      total++; if (d_ready !== 1'b1) $display("FAIL il_ready_%0d: got %0b expected 1", i, d_ready); else passed++;
      step();
      if (i[0] == 1'b0) begin
        total++; if (a !== words[i] || a_valid !== 1'b1) $display("FAIL il_a_%0d: got a=%0d v=%0b expected a=%0d v=1", i, a, a_valid, words[i]); else passed++;
      end else begin
        total++; if (b !== words[i] || b_valid !== 1'b1) $display("FAIL il_b_%0d: got b=%0d v=%0b expected b=%0d v=1", i, b, b_valid, words[i]); else passed++;
      end
    end
    d_valid = 1'b0;
    step();
    total++; if (a_count !== 8'd3 || b_count !== 8'd4) $display("FAIL il_counts: got %0d/%0d expected 3/4", a_count, b_count); else passed++;
    total++; if (a_valid !== 1'b0 || b_valid !== 1'b0) $display("FAIL il_drained: got %0b%0b expected 00", a_valid, b_valid); else passed++;
  endtask

  task automatic test_counter_wrap();
    Rst = 1'b0; d_valid = 1'b0;
    step();
    Rst = 1'b1;
    a_ready = 1'b1; sel = 1'b0; d_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      d = i[7:0];
      step();
    end
    // 256 accepted, 255 delivered so far; word 255 is sitting in a
    total++; if (a_count !== 8'd255) $display("FAIL wrap_255: got %0d expected 255", a_count); else passed++;
    total++; if (a !== 8'd255 || a_valid !== 1'b1) $display("FAIL wrap_last_word: got a=%0d v=%0b expected a=255 v=1", a, a_valid); else passed++;
    d_valid = 1'b0;
    step();
    total++; if (a_count !== 8'd0) $display("FAIL wrap_zero: got %0d expected 0", a_count); else passed++;
    d = 8'hab; d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    step();
    total++; if (a_count !== 8'd1) $display("FAIL wrap_257: got %0d expected 1", a_count); else passed++;
    total++; if (a !== 8'hab) $display("FAIL wrap_257_data: got %0h expected ab", a); else passed++;
  endtask

  task automatic test_mid_reset();
    a_ready = 1'b0; b_ready = 1'b0;
    d = 8'd42; sel = 1'b0; d_valid = 1'b1;
    step();
    d = 8'd77; sel = 1'b1;
    step();
    d_valid = 1'b0;
    total++; if (a !== 8'd42 || b !== 8'd77 || a_valid !== 1'b1 || b_valid !== 1'b1) $display("FAIL mr_loaded: got a=%0d b=%0d v=%0b%0b expected 42 77 11", a, b, a_valid, b_valid); else passed++;
    Rst = 1'b0;
    settle();
    total++; if (d_ready !== 1'b0) $display("FAIL mr_d_ready: got %0b expected 0", d_ready); else passed++;
    step();
    Rst = 1'b1;
    total++; if (a_valid !== 1'b0 || b_valid !== 1'b0) $display("FAIL mr_valids: got %0b%0b expected 00", a_valid, b_valid); else passed++;
    total++; if (a_count !== 8'd0 || b_count !== 8'd0) $display("FAIL mr_counts: got %0d/%0d expected 0/0", a_count, b_count); else passed++;
    total++; if (a !== 8'd0 || b !== 8'd0) $display("FAIL mr_data: got %0d/%0d expected 0/0", a, b); else passed++;
    // resume: the discarded words must not show up as deliveries
    b_ready = 1'b1; a_ready = 1'b1;
    d = 8'd5; sel = 1'b1; d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    total++; if (b !== 8'd5 || b_valid !== 1'b1) $display("FAIL mr_resume_load: got b=%0d v=%0b expected b=5 v=1", b, b_valid); else passed++;
    step();
    total++; if (b_count !== 8'd1 || a_count !== 8'd0) $display("FAIL mr_resume_counts: got %0d/%0d expected 0/1", a_count, b_count); else passed++;
  endtask

  initial begin
    Rst = 1'b0; d = '0; sel = 1'b0; d_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    #1;
    test_reset();
    test_single_steer();
    test_backpressure();
    test_interleave();
    test_counter_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
